// File: rtl/port_rd_ctrl.sv
// rtl/port_rd_ctrl.sv - output-port read controller: FIFO pop FSM, latency tracking, credit-bounded output buffer
module port_rd_ctrl #(
  parameter int W_WIDTH   = 8,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4,
  parameter int LEN_BITS  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [W_WIDTH-1:0] fifo_rd_data,
  output logic [W_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic               pkt_done,
  output logic               busy
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]         DEPTH_C  = (CW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0]       CNT_ONE  = 1;
  localparam logic [PW-1:0]       PTR_ONE  = 1;
  localparam logic [PW-1:0]       PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [LEN_BITS-1:0] REM_ONE  = 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HDR_WAIT = 2'd1;
  localparam logic [1:0] S_PAYLOAD  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic [RD_LAT-1:0]   fl_vld_q, fl_sop_q, fl_eop_q;
  logic [W_WIDTH-1:0]  buf_data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_sop_q, buf_eop_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d, inflight;
  logic [CW:0]         used;
  logic                can_pop, rd_en, pop_sop, pop_eop;
  logic                arr_vld, arr_sop, arr_eop;
  logic [LEN_BITS-1:0] hdr_len;
  logic                push, pop, pkt_done_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {{(CW-1){1'b0}}, fl_vld_q[i]};
    end
  end

  // Reads in flight reserve a buffer slot, so the buffer can never overflow.
  assign used    = {1'b0, count_q} + {1'b0, inflight};
  assign can_pop = !fifo_empty && (used < DEPTH_C);

  assign arr_vld = fl_vld_q[RD_LAT-1];
  assign arr_sop = fl_sop_q[RD_LAT-1];
  assign hdr_len = fifo_rd_data[LEN_BITS-1:0];
  assign arr_eop = fl_eop_q[RD_LAT-1] | (arr_sop & (hdr_len == '0));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rd_en   = 1'b0;
    pop_sop = 1'b0;
    pop_eop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          rd_en   = 1'b1;
          pop_sop = 1'b1;
          state_d = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        if (arr_vld && arr_sop) begin
          rem_d   = hdr_len;
          state_d = (hdr_len == '0) ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (can_pop) begin
          rd_en = 1'b1;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            pop_eop = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_rd_en = rd_en;

  assign push = arr_vld;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      fl_vld_q   <= '0;
      fl_sop_q   <= '0;
      fl_eop_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      buf_sop_q  <= '0;
      buf_eop_q  <= '0;
      pkt_done_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        fl_vld_q[i] <= fl_vld_q[i-1];
        fl_sop_q[i] <= fl_sop_q[i-1];
        fl_eop_q[i] <= fl_eop_q[i-1];
      end
      fl_vld_q[0] <= rd_en;
      fl_sop_q[0] <= pop_sop;
      fl_eop_q[0] <= pop_eop;
      if (push) begin
        buf_data_q[wr_ptr_q] <= fifo_rd_data;
        buf_sop_q[wr_ptr_q]  <= arr_sop;
        buf_eop_q[wr_ptr_q]  <= arr_eop;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
      count_q    <= count_d;
      pkt_done_q <= pop && out_eop;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_sop   = buf_sop_q[rd_ptr_q];
  assign out_eop   = buf_eop_q[rd_ptr_q];
  assign pkt_done  = pkt_done_q;
  assign busy      = (state_q != S_IDLE) || (fl_vld_q != '0) || (count_q != '0);

endmodule
